// File: rtl/fury_pkg.sv
// Shared definitions for the enemy-car controllers.
// Contents: FSM state encoding, screen and sprite geometry, frame timing constants
// and the lane x-position table.
// No ports (package).
package fury_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StHit    = 2'd2
    } enemy_state_e;

    localparam int unsigned H_VIS        = 640;
    localparam int unsigned V_VIS        = 480;
    localparam int unsigned SPRITE_W     = 60;
    localparam int unsigned SPRITE_H     = 60;
    localparam int unsigned Y_END        = V_VIS;
    localparam int unsigned V_TICK_LINE  = 481;
    localparam int unsigned SPEED_INIT   = 2;
    localparam int unsigned SPAWN_FRAMES = 30;
    localparam int unsigned HIT_FRAMES   = 32;

    localparam logic [9:0] LANE0_X = 10'd200;
    localparam logic [9:0] LANE1_X = 10'd260;
    localparam logic [9:0] LANE2_X = 10'd320;
    localparam logic [9:0] LANE3_X = 10'd380;

    function automatic logic [9:0] lane_x(input logic [1:0] lane);
        logic [9:0] x;
        unique case (lane)
            2'd0:    x = LANE0_X;
            2'd1:    x = LANE1_X;
            2'd2:    x = LANE2_X;
            default: x = LANE3_X;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/lfsr_carril.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick spawn lanes.
// Advances every clock; seeded with 8'hA5, so it never reaches the all-zero lock-up state.
// Ports:
//   clock_i   pixel clock
//   reset_ni  asynchronous active-low reset
//   q_o       current LFSR state
module lfsr_carril (
    input  logic       clock_i,
    input  logic       reset_ni,
    output logic [7:0] q_o
);

    logic [7:0] q_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            q_q <= 8'hA5;
        end else begin
            q_q <= {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/control_enemigo.sv
// Motion/spawn controller for one 60x60 enemy car sprite.
// Spawns the car in a pseudo-random lane, moves it down once per video frame, flags crash
// and pass events, and blinks the sprite after a hit.
// Optional feature: define SPEED_RAMP_EN to raise speed by 1 every 8th pass (saturating
// at 15) and reset it on crash; otherwise speed is constant.
// Ports:
//   clock_i, reset_ni        pixel clock, async active-low reset
//   run_i                    game running; low forces IDLE
//   hcount_i, vcount_i       VGA counters (frame tick source)
//   player_x_i, player_y_i   player sprite top-left
//   enable_o, posx_o, posy_o renderer controls
//   crash_o, passed_o        one-cycle event pulses
//   speed_o                  current descent speed in px/frame
module control_enemigo
    import fury_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic       run_i,
    input  logic [9:0] hcount_i,
    input  logic [9:0] vcount_i,
    input  logic [9:0] player_x_i,
    input  logic [9:0] player_y_i,
    output logic       enable_o,
    output logic [9:0] posx_o,
    output logic [9:0] posy_o,
    output logic       crash_o,
    output logic       passed_o,
    output logic [3:0] speed_o
);

    enemy_state_e state_q;
    logic         tick_d, tick_q;
    logic         enable_q, crash_q, passed_q;
    logic [9:0]   posx_q, posy_q;
    logic [4:0]   cnt_q, cnt_inc;
    logic [3:0]   speed;
    logic [7:0]   lfsr;
    logic         unused_lfsr;
    logic [10:0]  posy_next;
    logic [9:0]   dx;
    logic [10:0]  dy;
    logic         overlap, exits, crash_ev, pass_ev;

    lfsr_carril u_lfsr (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .q_o      (lfsr)
    );
    assign unused_lfsr = ^lfsr[7:2];

    always_comb begin
        tick_d    = (hcount_i == 10'd0) && (vcount_i == 10'(V_TICK_LINE));
        cnt_inc   = cnt_q + 5'd1;
        posy_next = {1'b0, posy_q} + {7'd0, speed};
        dx        = (posx_q >= player_x_i) ? posx_q - player_x_i : player_x_i - posx_q;
        dy        = (posy_next >= {1'b0, player_y_i}) ? posy_next - {1'b0, player_y_i}
                                                     : {1'b0, player_y_i} - posy_next;
        overlap   = (dx < 10'(SPRITE_W)) && (dy < 11'(SPRITE_H));
        // 11-bit sum so a car near the bottom cannot wrap past the retire check.
        exits     = (posy_next + 11'(SPRITE_H)) > 11'(Y_END);
        crash_ev  = run_i && tick_q && (state_q == StActive) && overlap;
        pass_ev   = run_i && tick_q && (state_q == StActive) && !overlap && exits;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            tick_q   <= 1'b0;
            enable_q <= 1'b0;
            posx_q   <= LANE0_X;
            posy_q   <= 10'd0;
            crash_q  <= 1'b0;
            passed_q <= 1'b0;
            cnt_q    <= 5'd0;
        end else begin
            tick_q   <= tick_d;
            crash_q  <= crash_ev;
            passed_q <= pass_ev;
            if (!run_i) begin
                state_q  <= StIdle;
                enable_q <= 1'b0;
                cnt_q    <= 5'd0;
            end else if (tick_q) begin
                unique case (state_q)
                    StIdle: begin
                        if (cnt_q == 5'(SPAWN_FRAMES - 1)) begin
                            state_q  <= StActive;
                            enable_q <= 1'b1;
                            posx_q   <= lane_x(lfsr[1:0]);
                            posy_q   <= 10'd0;
                            cnt_q    <= 5'd0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StActive: begin
                        posy_q <= posy_next[9:0];
                        // Crash takes priority over leaving the screen on the same tick.
                        if (overlap) begin
                            state_q  <= StHit;
                            enable_q <= 1'b0;
                            cnt_q    <= 5'd0;
                        end else if (exits) begin
                            state_q  <= StIdle;
                            enable_q <= 1'b0;
                            cnt_q    <= 5'd0;
                        end
                    end
                    StHit: begin
                        if (cnt_q == 5'(HIT_FRAMES - 1)) begin
                            state_q  <= StIdle;
                            enable_q <= 1'b0;
                            cnt_q    <= 5'd0;
                        end else begin
                            cnt_q    <= cnt_inc;
                            enable_q <= cnt_inc[2];
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        enable_q <= 1'b0;
                        cnt_q    <= 5'd0;
                    end
                endcase
            end
        end
    end

`ifdef SPEED_RAMP_EN
    logic [3:0] speed_q;
    logic [2:0] pass_cnt_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            speed_q    <= 4'(SPEED_INIT);
            pass_cnt_q <= 3'd0;
        end else if (crash_ev) begin
            speed_q    <= 4'(SPEED_INIT);
            pass_cnt_q <= 3'd0;
        end else if (pass_ev) begin
            pass_cnt_q <= pass_cnt_q + 3'd1;
            if ((pass_cnt_q == 3'd7) && (speed_q != 4'd15)) begin
                speed_q <= speed_q + 4'd1;
            end
        end
    end

    assign speed = speed_q;
`else
    assign speed = 4'(SPEED_INIT);
`endif

    assign enable_o = enable_q;
    assign posx_o   = posx_q;
    assign posy_o   = posy_q;
    assign crash_o  = crash_q;
    assign passed_o = passed_q;
    assign speed_o  = speed;

endmodule

// File: tb/tb_control_enemigo.sv
module tb_control_enemigo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [9:0] hc = 10'd1, vc = 10'd0, px = 10'd0, py = 10'd0;
    logic       enable, crash, passed;
    logic [9:0] posx, posy;
    logic [3:0] speed;

    int n_vec = 0;
    int n_err = 0;

    control_enemigo dut (
        .clock_i    (clk),
        .reset_ni   (rst_n),
        .run_i      (run),
        .hcount_i   (hc),
        .vcount_i   (vc),
        .player_x_i (px),
        .player_y_i (py),
        .enable_o   (enable),
        .posx_o     (posx),
        .posy_o     (posy),
        .crash_o    (crash),
        .passed_o   (passed),
        .speed_o    (speed)
    );

    always #5 clk = ~clk;

    // Reference LFSR; m_prev holds the value the DUT saw during the previous clock.
    logic [7:0] m_lfsr, m_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    function automatic logic [9:0] lane_of(input logic [1:0] l);
        case (l)
            2'd0:    return 10'd200;
            2'd1:    return 10'd260;
            2'd2:    return 10'd320;
            default: return 10'd380;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: tick line for one clock, then the update lands; returns on a negedge.
    task automatic frame();
        hc = 10'd0;
        vc = 10'd481;
        @(negedge clk);
        hc = 10'd5;
        vc = 10'd0;
        @(negedge clk);
    endtask

    logic [9:0] exp_x;
    int         cnt;
    int         y;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(enable), 0);
        chk("rst_posx", 32'(posx), 200);
        chk("rst_posy", 32'(posy), 0);
        chk("rst_crash", 32'(crash), 0);
        chk("rst_passed", 32'(passed), 0);
        chk("rst_speed", 32'(speed), 2);
        rst_n = 1'b1;
        run   = 1'b1;

        // Spawn after 30 ticks, then descend 2 px per tick.
        repeat (29) frame();
        chk("idle_29_en", 32'(enable), 0);
        frame();
        exp_x = lane_of(m_prev[1:0]);
        chk("spawn_en", 32'(enable), 1);
        chk("spawn_x", 32'(posx), 32'(exp_x));
        chk("spawn_y", 32'(posy), 0);
        frame();
        chk("desc_y1", 32'(posy), 2);
        frame();
        chk("desc_y2", 32'(posy), 4);
        cnt = 0;
        for (y = 4; y < 420; y += 2) begin
            frame();
            cnt += int'(passed);
        end
        chk("desc_y420", 32'(posy), 420);
        chk("no_early_pass", 32'(cnt), 0);
        frame();
        chk("pass_pulse", 32'(passed), 1);
        chk("pass_nocrash", 32'(crash), 0);
        chk("pass_en", 32'(enable), 0);
        chk("pass_y", 32'(posy), 422);
        @(negedge clk);
        chk("pass_width", 32'(passed), 0);
        repeat (29) frame();
        chk("respawn_wait", 32'(enable), 0);
        frame();
        exp_x = lane_of(m_prev[1:0]);
        chk("respawn_en", 32'(enable), 1);
        chk("respawn_x", 32'(posx), 32'(exp_x));

        // Player in the car's lane at y=300: crash when posy first exceeds 240.
        px  = exp_x;
        py  = 10'd300;
        cnt = 0;
        repeat (120) begin
            frame();
            cnt += int'(crash);
        end
        chk("pre_crash", 32'(cnt), 0);
        chk("pre_crash_y", 32'(posy), 240);
        frame();
        chk("crash_pulse", 32'(crash), 1);
        chk("crash_nopass", 32'(passed), 0);
        chk("crash_y", 32'(posy), 242);
        @(negedge clk);
        chk("crash_width", 32'(crash), 0);
        cnt = 0;
        for (int k = 1; k < 32; k++) begin
            frame();
            chk($sformatf("blink_%0d", k), 32'(enable), 32'((k >> 2) & 1));
            cnt += int'(passed) + int'(crash);
        end
        chk("hit_no_pulse", 32'(cnt), 0);
        chk("hit_frozen_x", 32'(posx), 32'(exp_x));
        chk("hit_frozen_y", 32'(posy), 242);
        frame();
        chk("hit_done_en", 32'(enable), 0);

        // Crash and exit on the same tick: crash only.
        px = 10'd0;
        py = 10'd430;
        repeat (30) frame();
        exp_x = lane_of(m_prev[1:0]);
        chk("sp3_en", 32'(enable), 1);
        cnt = 0;
        repeat (210) begin
            frame();
            cnt += int'(crash) + int'(passed);
        end
        chk("sp3_quiet", 32'(cnt), 0);
        chk("sp3_y", 32'(posy), 420);
        px = exp_x;
        frame();
        chk("both_crash", 32'(crash), 1);
        chk("both_nopass", 32'(passed), 0);

        // Drop run mid-HIT while the sprite is lit.
        repeat (5) frame();
        chk("blink_lit", 32'(enable), 1);
        run = 1'b0;
        @(negedge clk);
        chk("rundrop_en", 32'(enable), 0);
        run = 1'b1;
        repeat (2) frame();
        chk("blink_stopped", 32'(enable), 0);
        chk("speed_kept", 32'(speed), 2);
        repeat (27) frame();
        chk("rundrop_wait", 32'(enable), 0);
        frame();
        chk("rundrop_spawn", 32'(enable), 1);
        repeat (3) frame();

        // Reset mid-ACTIVE.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_en", 32'(enable), 0);
        chk("mid_rst_x", 32'(posx), 200);
        chk("mid_rst_y", 32'(posy), 0);
        chk("mid_rst_speed", 32'(speed), 2);
        rst_n = 1'b1;

`ifdef SPEED_RAMP_EN
        px = 10'd0;
        py = 10'd0;
        for (int p = 0; p < 8; p++) begin
            chk($sformatf("ramp_pre_%0d", p), 32'(speed), 2);
            cnt = 0;
            for (int f = 0; f < 400 && !passed; f++) frame();
            chk($sformatf("ramp_pass_%0d", p), 32'(passed), 1);
            @(negedge clk);
        end
        chk("ramp_speed3", 32'(speed), 3);
        repeat (30) frame();
        px = lane_of(m_prev[1:0]);
        py = 10'd300;
        for (int f = 0; f < 400 && !crash; f++) frame();
        chk("ramp_crash", 32'(crash), 1);
        @(negedge clk);
        chk("ramp_crash_speed", 32'(speed), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
